// File: rtl/imm_gen_pkg.sv
// -----------------------------------------------------------------------------
// imm_gen_pkg
// Shared definitions for the RV64 immediate generator:
//   - XLEN          : output immediate width (only 64 is supported)
//   - OPC_*         : 7-bit major opcodes that carry an immediate
//   - imm_fmt_t     : 3-bit immediate format code (NONE/I/S/B/U/J)
// Optional build macro used by the generator: IMMG_BYTE_OFFSET_EN
// -----------------------------------------------------------------------------
package imm_gen_pkg;

   localparam int XLEN = 64;

   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5
   } imm_fmt_t;

endpackage : imm_gen_pkg

// File: rtl/imm_gen_dec.sv
// -----------------------------------------------------------------------------
// imm_gen_dec
// Purely combinational opcode -> immediate format decoder.
// Ports:
//   opcode_i  in  7  instruction major opcode (inst[6:0])
//   fmt_o     out 3  immediate format code (imm_fmt_t encoding)
// Unlisted opcodes decode to NONE.
// -----------------------------------------------------------------------------
module imm_gen_dec
   import imm_gen_pkg::*;
(
   input  logic [6:0] opcode_i,
   output logic [2:0] fmt_o
);

   imm_fmt_t fmt;

   always_comb begin
      fmt = FMT_NONE;
      case (opcode_i)
         OPC_LOAD, OPC_OPIMM, OPC_OPIMM32, OPC_JALR: fmt = FMT_I;
         OPC_STORE:                                  fmt = FMT_S;
         OPC_BRANCH:                                 fmt = FMT_B;
         OPC_LUI, OPC_AUIPC:                         fmt = FMT_U;
         OPC_JAL:                                    fmt = FMT_J;
         default:                                    fmt = FMT_NONE;
      endcase
   end

   assign fmt_o = fmt;

endmodule : imm_gen_dec

// File: rtl/imm_gen.sv
// -----------------------------------------------------------------------------
// imm_gen
// Decode-stage immediate generator for RV64. Extracts the immediate field of a
// 32-bit instruction, extends it to XLEN bits, and also keeps a registered
// copy (immediate, format, valid) for the decode/execute pipeline register.
// Ports:
//   clk      in   1     rising-edge clock for the registered outputs
//   rst_n    in   1     asynchronous active-low reset (registered outputs only)
//   inst     in   32    instruction word
//   load_en  in   1     capture enable for the registered outputs
//   imm      out  XLEN  combinational immediate
//   fmt      out  3     combinational format code
//   imm_q    out  XLEN  registered imm
//   fmt_q    out  3     registered fmt
//   valid_q  out  1     registered flag: captured format was not NONE
// Build macro:
//   IMMG_BYTE_OFFSET_EN  when defined, B and J immediates are byte offsets
//                        (field shifted left by one); otherwise halfword counts.
// -----------------------------------------------------------------------------
module imm_gen
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 64   // only 64 is supported
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [31:0]     inst,
   input  logic            load_en,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      fmt,
   output logic [XLEN-1:0] imm_q,
   output logic [2:0]      fmt_q,
   output logic            valid_q
);

   logic [2:0]      fmt_dec;
   logic [XLEN-1:0] imm_i_fmt;
   logic [XLEN-1:0] imm_s_fmt;
   logic [XLEN-1:0] imm_b_fmt;
   logic [XLEN-1:0] imm_u_fmt;
   logic [XLEN-1:0] imm_j_fmt;
   logic [11:0]     b_field;
   logic [19:0]     j_field;

   // next-state values for the pipeline register
   logic [XLEN-1:0] imm_d;
   logic [2:0]      fmt_d;
   logic            valid_d;

   imm_gen_dec u_dec (
      .opcode_i (inst[6:0]),
      .fmt_o    (fmt_dec)
   );

   assign b_field = {inst[31], inst[7], inst[30:25], inst[11:8]};
   // J field order is fixed by the decode contract of the downstream operand
   // muxes, not the ISA's architectural bit scramble.
   assign j_field = {inst[31], inst[21:12], inst[22], inst[30:23]};

   assign imm_i_fmt = {{(XLEN-12){inst[31]}}, inst[31:20]};
   assign imm_s_fmt = {{(XLEN-12){inst[31]}}, inst[31:25], inst[11:7]};
   assign imm_u_fmt = {{(XLEN-32){inst[31]}}, inst[31:12], 12'b0};

`ifdef IMMG_BYTE_OFFSET_EN
   // Byte offsets: B becomes a 13-bit signed field, J a 21-bit unsigned field.
   assign imm_b_fmt = {{(XLEN-13){inst[31]}}, b_field, 1'b0};
   assign imm_j_fmt = {{(XLEN-21){1'b0}}, j_field, 1'b0};
`else
   // Halfword counts: fields are emitted unshifted.
   assign imm_b_fmt = {{(XLEN-12){inst[31]}}, b_field};
   assign imm_j_fmt = {{(XLEN-20){1'b0}}, j_field};
`endif

   always_comb begin
      imm = '0;
      fmt = fmt_dec;
      case (imm_fmt_t'(fmt_dec))
         FMT_I:   imm = imm_i_fmt;
         FMT_S:   imm = imm_s_fmt;
         FMT_B:   imm = imm_b_fmt;
         FMT_U:   imm = imm_u_fmt;
         FMT_J:   imm = imm_j_fmt;
         default: begin
            imm = '0;
            fmt = FMT_NONE;
         end
      endcase
   end

   assign imm_d   = imm;
   assign fmt_d   = fmt;
   assign valid_d = (fmt != FMT_NONE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         imm_q   <= '0;
         fmt_q   <= FMT_NONE;
         valid_q <= 1'b0;
      end else if (load_en) begin
         imm_q   <= imm_d;
         fmt_q   <= fmt_d;
         valid_q <= valid_d;
      end
   end

endmodule : imm_gen

// File: tb/tb_imm_gen.sv
// -----------------------------------------------------------------------------
// tb_imm_gen
// Directed self-checking bench for imm_gen. Honours IMMG_BYTE_OFFSET_EN for the
// B and J expectations.
// -----------------------------------------------------------------------------
module tb_imm_gen;

   logic        clk;
   logic        rst_n;
   logic [31:0] inst;
   logic        load_en;
   logic [63:0] imm;
   logic [2:0]  fmt;
   logic [63:0] imm_q;
   logic [2:0]  fmt_q;
   logic        valid_q;

   int checks;
   int errors;

   localparam logic [2:0] F_NONE = 3'd0;
   localparam logic [2:0] F_I    = 3'd1;
   localparam logic [2:0] F_S    = 3'd2;
   localparam logic [2:0] F_B    = 3'd3;
   localparam logic [2:0] F_U    = 3'd4;
   localparam logic [2:0] F_J    = 3'd5;

   // Test-plan vectors
   localparam logic [31:0] INST_B_POS = 32'h0FFF_FF63; // bits[31:7]=0000111..10
   localparam logic [31:0] INST_B_NEG = 32'h8000_0063; // only inst[31] set
   localparam logic [31:0] INST_J     = 32'h9E4F_C06F; // {1,00111100,1,0011111100,00000,JAL}
   localparam logic [31:0] INST_J_TOP = 32'h8000_006F; // only inst[31] set

`ifdef IMMG_BYTE_OFFSET_EN
   localparam logic [63:0] EXP_B_POS = 64'h0000_0000_0000_00FE;
   localparam logic [63:0] EXP_B_NEG = 64'hFFFF_FFFF_FFFF_F000;
   localparam logic [63:0] EXP_J     = 64'h0000_0000_0013_F278;
   localparam logic [63:0] EXP_J_TOP = 64'h0000_0000_0010_0000;
`else
   localparam logic [63:0] EXP_B_POS = 64'h0000_0000_0000_007F;
   localparam logic [63:0] EXP_B_NEG = 64'hFFFF_FFFF_FFFF_F800;
   localparam logic [63:0] EXP_J     = 64'h0000_0000_0009_F93C;
   localparam logic [63:0] EXP_J_TOP = 64'h0000_0000_0008_0000;
`endif

   imm_gen dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .inst    (inst),
      .load_en (load_en),
      .imm     (imm),
      .fmt     (fmt),
      .imm_q   (imm_q),
      .fmt_q   (fmt_q),
      .valid_q (valid_q)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset();
      rst_n   = 1'b0;
      load_en = 1'b1;
      inst    = 32'h5550_0003;
      #2;
      checks++;
      if (imm_q !== 64'd0 || fmt_q !== F_NONE || valid_q !== 1'b0) begin
         errors++;
         $display("FAIL reset_state: imm_q=%h fmt_q=%0d valid_q=%b, need 0/0/0", imm_q, fmt_q, valid_q);
      end
      // edges while held in reset must not capture
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (imm_q !== 64'd0 || fmt_q !== F_NONE || valid_q !== 1'b0) begin
         errors++;
         $display("FAIL reset_hold: imm_q=%h fmt_q=%0d valid_q=%b, need 0/0/0", imm_q, fmt_q, valid_q);
      end
      @(negedge clk);
      load_en = 1'b0;
      rst_n   = 1'b1;
   endtask

   task automatic test_none();
      logic [31:0] vec [3];
      vec[0] = 32'h0000_0000;
      vec[1] = 32'hFFFF_FF7F;
      vec[2] = 32'h1234_5633;  // OP (R-type), no immediate
      for (int i = 0; i < 3; i++) begin
         inst = vec[i];
         #1;
         checks++;
         if (imm !== 64'd0 || fmt !== F_NONE) begin
            errors++;
            $display("FAIL none_%0d: inst=%h imm=%h fmt=%0d, need 0/0", i, inst, imm, fmt);
         end
      end
      // capture of NONE gives valid_q=0
      @(negedge clk);
      inst    = 32'h0000_0000;
      load_en = 1'b1;
      @(posedge clk);
      #1;
      load_en = 1'b0;
      checks++;
      if (valid_q !== 1'b0 || fmt_q !== F_NONE || imm_q !== 64'd0) begin
         errors++;
         $display("FAIL none_capture: valid_q=%b fmt_q=%0d imm_q=%h, need 0/0/0", valid_q, fmt_q, imm_q);
      end
   endtask

   task automatic test_itype();
      logic [31:0] vin [5];
      logic [63:0] vexp [5];
      vin[0] = 32'h5550_0003; vexp[0] = 64'h0000_0000_0000_0555; // LOAD
      vin[1] = 32'hFFF0_0003; vexp[1] = 64'hFFFF_FFFF_FFFF_FFFF; // LOAD, -1
      vin[2] = 32'h8000_0013; vexp[2] = 64'hFFFF_FFFF_FFFF_F800; // OP-IMM, min
      vin[3] = 32'h7FF0_001B; vexp[3] = 64'h0000_0000_0000_07FF; // OP-IMM-32, max
      vin[4] = 32'h0040_0067; vexp[4] = 64'h0000_0000_0000_0004; // JALR
      for (int i = 0; i < 5; i++) begin
         inst = vin[i];
         #1;
         checks++;
         if (imm !== vexp[i] || fmt !== F_I) begin
            errors++;
            $display("FAIL itype_%0d: inst=%h imm=%h fmt=%0d, need %h/%0d", i, inst, imm, fmt, vexp[i], F_I);
         end
      end
   endtask

   task automatic test_stype();
      inst = 32'h5400_0AA3;
      #1;
      checks++;
      if (imm !== 64'h555 || fmt !== F_S) begin
         errors++;
         $display("FAIL stype_pos: imm=%h fmt=%0d, need 555/%0d", imm, fmt, F_S);
      end
      inst = 32'hFE00_0FA3;  // all S field bits set
      #1;
      checks++;
      if (imm !== 64'hFFFF_FFFF_FFFF_FFFF || fmt !== F_S) begin
         errors++;
         $display("FAIL stype_neg: imm=%h fmt=%0d, need all-ones/%0d", imm, fmt, F_S);
      end
   endtask

   task automatic test_btype();
      inst = INST_B_POS;
      #1;
      checks++;
      if (imm !== EXP_B_POS || fmt !== F_B) begin
         errors++;
         $display("FAIL btype_pos: imm=%h fmt=%0d, need %h/%0d", imm, fmt, EXP_B_POS, F_B);
      end
      inst = INST_B_NEG;
      #1;
      checks++;
      if (imm !== EXP_B_NEG || fmt !== F_B) begin
         errors++;
         $display("FAIL btype_neg: imm=%h fmt=%0d, need %h/%0d", imm, fmt, EXP_B_NEG, F_B);
      end
   endtask

   task automatic test_utype();
      inst = 32'h8000_0037;  // LUI
      #1;
      checks++;
      if (imm !== 64'hFFFF_FFFF_8000_0000 || fmt !== F_U) begin
         errors++;
         $display("FAIL utype_lui: imm=%h fmt=%0d, need ffffffff80000000/%0d", imm, fmt, F_U);
      end
      inst = 32'h1234_5017;  // AUIPC
      #1;
      checks++;
      if (imm !== 64'h0000_0000_1234_5000 || fmt !== F_U) begin
         errors++;
         $display("FAIL utype_auipc: imm=%h fmt=%0d, need 12345000/%0d", imm, fmt, F_U);
      end
   endtask

   task automatic test_jtype();
      inst = INST_J;
      #1;
      checks++;
      if (imm !== EXP_J || fmt !== F_J) begin
         errors++;
         $display("FAIL jtype: imm=%h fmt=%0d, need %h/%0d", imm, fmt, EXP_J, F_J);
      end
      inst = INST_J_TOP;  // top field bit set: upper bits must stay zero
      #1;
      checks++;
      if (imm !== EXP_J_TOP || fmt !== F_J) begin
         errors++;
         $display("FAIL jtype_zext: imm=%h fmt=%0d, need %h/%0d", imm, fmt, EXP_J_TOP, F_J);
      end
   endtask

   task automatic test_hold();
      @(negedge clk);
      inst    = 32'h5550_0003;
      load_en = 1'b1;
      @(posedge clk);
      #1;
      checks++;
      if (imm_q !== 64'h555 || fmt_q !== F_I || valid_q !== 1'b1) begin
         errors++;
         $display("FAIL hold_capture: imm_q=%h fmt_q=%0d valid_q=%b, need 555/%0d/1", imm_q, fmt_q, valid_q, F_I);
      end
      @(negedge clk);
      load_en = 1'b0;
      inst    = 32'h8000_0037;
      repeat (2) @(posedge clk);
      #1;
      checks++;
      if (imm_q !== 64'h555 || fmt_q !== F_I || valid_q !== 1'b1) begin
         errors++;
         $display("FAIL hold_stable: imm_q=%h fmt_q=%0d valid_q=%b, need 555/%0d/1", imm_q, fmt_q, valid_q, F_I);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] vin [3];
      logic [63:0] vexp [3];
      logic [2:0]  fexp [3];
      vin[0] = 32'h5400_0AA3; vexp[0] = 64'h555;      fexp[0] = F_S;
      vin[1] = INST_J;        vexp[1] = EXP_J;        fexp[1] = F_J;
      vin[2] = INST_B_NEG;    vexp[2] = EXP_B_NEG;    fexp[2] = F_B;
      load_en = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         inst = vin[i];
         @(posedge clk);
         #1;
         checks++;
         if (imm_q !== vexp[i] || fmt_q !== fexp[i] || valid_q !== 1'b1) begin
            errors++;
            $display("FAIL b2b_%0d: imm_q=%h fmt_q=%0d valid_q=%b, need %h/%0d/1", i, imm_q, fmt_q, valid_q, vexp[i], fexp[i]);
         end
      end
      @(negedge clk);
      load_en = 1'b0;
   endtask

   task automatic test_async_reset();
      // registers currently hold the last back-to-back capture (nonzero)
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (imm_q !== 64'd0 || fmt_q !== F_NONE || valid_q !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: imm_q=%h fmt_q=%0d valid_q=%b, need 0/0/0", imm_q, fmt_q, valid_q);
      end
      // combinational path is unaffected by reset
      inst = 32'h8000_0037;
      #1;
      checks++;
      if (imm !== 64'hFFFF_FFFF_8000_0000 || fmt !== F_U) begin
         errors++;
         $display("FAIL comb_in_reset: imm=%h fmt=%0d, need ffffffff80000000/%0d", imm, fmt, F_U);
      end
      @(negedge clk);
      rst_n   = 1'b1;
      load_en = 1'b1;
      @(posedge clk);
      #1;
      load_en = 1'b0;
      checks++;
      if (imm_q !== 64'hFFFF_FFFF_8000_0000 || fmt_q !== F_U || valid_q !== 1'b1) begin
         errors++;
         $display("FAIL first_capture: imm_q=%h fmt_q=%0d valid_q=%b, need ffffffff80000000/%0d/1", imm_q, fmt_q, valid_q, F_U);
      end
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      rst_n   = 1'b0;
      load_en = 1'b0;
      inst    = 32'h0;
      test_reset();
      test_none();
      test_itype();
      test_stype();
      test_btype();
      test_utype();
      test_jtype();
      test_hold();
      test_back_to_back();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule : tb_imm_gen
